// File: rtl/rf_multiport.sv
// rf_multiport: 2-read / 2-write register file with a per-entry pending-write
// scoreboard and a multi-cycle bulk-clear sequencer.
//
// Optional feature: define RF_BYPASS_EN to forward same-cycle accepted writes
// (data and scoreboard clear) to the combinational read ports.
//
// Ports:
//   clk               clock, all state updates on posedge
//   rst               synchronous active-high reset
//   ra1, ra2          read addresses
//   rd1, rd2          read data (combinational)
//   busy1, busy2      scoreboard bit for ra1 / ra2 (combinational)
//   we1, we2          write enables
//   wa1, wa2          write addresses
//   wd1, wd2          write data
//   sb_set, sb_addr   mark entry sb_addr as pending
//   clr_req           start bulk clear
//   clr_busy          clear sequence in progress
//   wr_ready          writes and sb_set are accepted this cycle
module rf_multiport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] wa1,
  input  logic [AW-1:0] wa2,
  input  logic [DW-1:0] wd1,
  input  logic [DW-1:0] wd2,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_addr,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          wr_ready
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_reg;
  logic [AW-1:0]    idx_reg;
  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] sb_reg;
  logic [DEPTH-1:0] sb_next;

  logic idle;
  logic acc1, acc2, set_ok;

  // Entry 0 is hardwired when ZERO_REG is set.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign idle     = (state_reg == IDLE);
  assign clr_busy = !idle;
  assign wr_ready = idle;

  // Accepted (not dropped) writes and scoreboard set for this cycle.
  assign acc1   = we1 && idle && !is_zero(wa1);
  assign acc2   = we2 && idle && !is_zero(wa2);
  assign set_ok = sb_set && idle && !is_zero(sb_addr);

  // Read ports handled uniformly through small arrays.
  logic [AW-1:0] ra_arr   [2];
  logic [DW-1:0] rd_arr   [2];
  logic          busy_arr [2];

  assign ra_arr[0] = ra1;
  assign ra_arr[1] = ra2;
  assign rd1       = rd_arr[0];
  assign rd2       = rd_arr[1];
  assign busy1     = busy_arr[0];
  assign busy2     = busy_arr[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_arr[gi]   = mem[ra_arr[gi]];
        busy_arr[gi] = sb_reg[ra_arr[gi]];
`ifdef RF_BYPASS_EN
        // acc1/acc2 are already false in CLEAR and for entry 0 under ZERO_REG,
        // so no extra qualification is needed here. Port 2 has priority.
        if (acc2 && (wa2 == ra_arr[gi])) begin
          rd_arr[gi] = wd2;
        end else if (acc1 && (wa1 == ra_arr[gi])) begin
          rd_arr[gi] = wd1;
        end
        if (((acc1 && (wa1 == ra_arr[gi])) || (acc2 && (wa2 == ra_arr[gi])))
            && !(set_ok && (sb_addr == ra_arr[gi]))) begin
          busy_arr[gi] = 1'b0;
        end
`endif
        if (is_zero(ra_arr[gi])) begin
          rd_arr[gi]   = '0;
          busy_arr[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // Scoreboard next state: writes clear, then set overrides (set wins).
  always_comb begin
    sb_next = sb_reg;
    if (idle) begin
      if (acc1)   sb_next[wa1]     = 1'b0;
      if (acc2)   sb_next[wa2]     = 1'b0;
      if (set_ok) sb_next[sb_addr] = 1'b1;
    end else begin
      sb_next[idx_reg] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      sb_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      sb_reg <= sb_next;
      case (state_reg)
        IDLE: begin
          // Port 2 is written last so it wins on an address collision.
          if (acc1) mem[wa1] <= wd1;
          if (acc2) mem[wa2] <= wd2;
          if (clr_req) begin
            state_reg <= CLEAR;
            idx_reg   <= '0;
          end
        end
        CLEAR: begin
          mem[idx_reg] <= '0;
          // idx naturally wraps to 0 after the last entry.
          idx_reg <= idx_reg + 1'b1;
          if (idx_reg == AW'(DEPTH - 1)) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          idx_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed scenarios followed by random traffic, checked
// against an array-based reference model of the register file.
module tb_rf_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa1, wa2, sb_addr;
  logic [DW-1:0] rd1, rd2, wd1, wd2;
  logic          busy1, busy2, we1, we2, sb_set, clr_req, clr_busy, wr_ready;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_sb  [DEPTH];
  bit            m_clr;
  int            m_pos;

  rf_multiport #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    if (ra == 0) return '0;
    v = m_mem[ra];
`ifdef RF_BYPASS_EN
    if (!m_clr) begin
      if (we2 && wa2 == ra) v = wd2;
      else if (we1 && wa1 == ra) v = wd1;
    end
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    logic b;
    if (ra == 0) return 1'b0;
    b = m_sb[ra];
`ifdef RF_BYPASS_EN
    if (!m_clr && ((we1 && wa1 == ra) || (we2 && wa2 == ra)) && !(sb_set && sb_addr == ra))
      b = 1'b0;
`endif
    return b;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_sb[i]  = 1'b0;
      end
      m_clr = 1'b0;
      m_pos = 0;
    end else if (m_clr) begin
      m_mem[m_pos] = '0;
      m_sb[m_pos]  = 1'b0;
      m_pos++;
      if (m_pos == DEPTH) begin
        m_clr = 1'b0;
        m_pos = 0;
      end
    end else begin
      if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_sb[wa1] = 1'b0; end
      if (we2 && wa2 != 0) begin m_mem[wa2] = wd2; m_sb[wa2] = 1'b0; end
      if (sb_set && sb_addr != 0) m_sb[sb_addr] = 1'b1;
      if (clr_req) begin
        m_clr = 1'b1;
        m_pos = 0;
      end
    end
  endtask

  task automatic idle_in();
    rst = 0; we1 = 0; we2 = 0; sb_set = 0; clr_req = 0;
  endtask

  // Check outputs mid-cycle against the model, then clock one edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    chk({tag, "_rd1"}, rd1, exp_rd(ra1));
    chk({tag, "_rd2"}, rd2, exp_rd(ra2));
    chk({tag, "_busy1"}, DW'(busy1), DW'(exp_busy(ra1)));
    chk({tag, "_busy2"}, DW'(busy2), DW'(exp_busy(ra2)));
    chk({tag, "_clr_busy"}, DW'(clr_busy), DW'(m_clr));
    chk({tag, "_wr_ready"}, DW'(wr_ready), DW'(!m_clr));
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int n;
    idle_in();
    ra1 = 0; ra2 = 0; wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0; sb_addr = 0;
    m_clr = 0; m_pos = 0;

    // Reset
    rst = 1;
    repeat (2) @(posedge clk);
    model_step();
    #1;
    rst = 0;

    // 1: every entry reads zero and idle after reset
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i); ra2 = AW'(DEPTH - 1 - i);
      cycle("t1");
    end
    chk("t1_rd1_const", rd1, '0);
    chk("t1_wr_ready_const", DW'(wr_ready), 32'd1);

    // 2: dual write to the same entry, port 2 wins
    we1 = 1; wa1 = 3; wd1 = 32'hAAAA0001;
    we2 = 1; wa2 = 3; wd2 = 32'h55550002;
    ra1 = 3;
    cycle("t2w");
    idle_in();
    #1 chk("t2_port2_wins", rd1, 32'h55550002);
    cycle("t2r");

    // 3: entry 0 ignores writes and sb_set
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; sb_set = 1; sb_addr = 0; ra1 = 0;
    cycle("t3w");
    idle_in();
    #1;
    chk("t3_rd_zero", rd1, '0);
    chk("t3_busy_zero", DW'(busy1), '0);

    // 4: scoreboard set-wins and later clear
    sb_set = 1; sb_addr = 7; ra1 = 7;
    cycle("t4set");
    idle_in();
    cycle("t4gap");
    we1 = 1; wa1 = 7; wd1 = 32'h0000_0077; sb_set = 1; sb_addr = 7;
    cycle("t4both");
    idle_in();
    #1 chk("t4_busy_held", DW'(busy1), 32'd1);
    we1 = 1; wa1 = 7; wd1 = 32'h0000_0078;
    cycle("t4wr");
    idle_in();
    #1 chk("t4_busy_cleared", DW'(busy1), 32'd0);

    // 5: fill entries, then bulk clear
    for (int i = 1; i < DEPTH; i++) begin
      we1 = 1; wa1 = AW'(i); wd1 = DW'(i); ra1 = AW'(i); ra2 = AW'(i - 1);
      cycle("t5fill");
    end
    idle_in();
    ra1 = 5; ra2 = 31;
    clr_req = 1;
    cycle("t5req");
    clr_req = 0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      idle_in();
      if (n == 3) begin we1 = 1; wa1 = 5; wd1 = 32'hDEAD0005; end
      if (n == 10 || n == 31) clr_req = 1;   // ignored mid-clear and on exit cycle
      ra1 = 5; ra2 = AW'(n);
      cycle("t5clr");
      n++;
    end
    idle_in();
    chk("t5_clear_cycles", DW'(n), 32'd32);
    #1;
    chk("t5_clr_busy_done", DW'(clr_busy), 32'd0);
    chk("t5_wr_ready_done", DW'(wr_ready), 32'd1);
    chk("t5_entry5_dropped", rd1, '0);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i); ra2 = AW'((i + 7) % DEPTH);
      cycle("t5read");
    end

    // 6: reset during clear, then same-cycle read of a write
    clr_req = 1;
    cycle("t6req");
    clr_req = 0;
    for (int i = 0; i < 9; i++) cycle("t6clr");
    rst = 1;
    cycle("t6rst");
    rst = 0;
    #1;
    chk("t6_clr_busy_after_rst", DW'(clr_busy), 32'd0);
    chk("t6_wr_ready_after_rst", DW'(wr_ready), 32'd1);
    we1 = 1; wa1 = 9; wd1 = 32'h1234; ra1 = 9;
    cycle("t6byp");
    idle_in();
    cycle("t6after");

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(0, 249) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      we1     = !rst && $urandom_range(0, 1);
      we2     = !rst && $urandom_range(0, 1);
      sb_set  = !rst && ($urandom_range(0, 2) == 0);
      wa1     = AW'($urandom_range(0, DEPTH - 1));
      wa2     = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, DEPTH - 1));
      sb_addr = ($urandom_range(0, 2) == 0) ? wa2 : AW'($urandom_range(0, DEPTH - 1));
      wd1     = $urandom;
      wd2     = $urandom;
      ra1     = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom_range(0, DEPTH - 1));
      ra2     = ($urandom_range(0, 2) == 0) ? wa2 : AW'($urandom_range(0, DEPTH - 1));
      cycle("rnd");
    end
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
